// File: rtl/wb_vga_fill_if.sv
// -----------------------------------------------------------------------------
// wb_vga_fill_if
// Wishbone classic write bus between the fill engine (master) and the
// framebuffer memory (slave).
//   cyc, stb, we : master cycle / strobe / write-enable
//   addr[15:0]   : framebuffer word address
//   data[31:0]   : write data, two RGB565 pixels per word
//   sel[3:0]     : byte lanes, 1100 = even pixel, 0011 = odd pixel
//   ack          : slave acknowledge, may rise in the same cycle as stb
// -----------------------------------------------------------------------------
interface wb_vga_fill_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [15:0] addr;
   logic [31:0] data;
   logic [3:0]  sel;
   logic        ack;

   modport master (output cyc, output stb, output we, output addr,
                   output data, output sel, input ack);
   modport slave  (input cyc, input stb, input we, input addr,
                   input data, input sel, output ack);
endinterface

// File: rtl/wb_vga_fill.sv
// -----------------------------------------------------------------------------
// wb_vga_fill
// Rectangle fill engine: writes an RGB565 colour into a rectangle of a packed
// 16-bit framebuffer (two pixels per 32-bit word) over Wishbone classic.
// Ports:
//   i_clk, i_reset_n    : clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready, i_x0, i_y0, i_w, i_h, i_color : fill command
//   i_abort             : stop the fill in progress
//   o_busy, o_done, o_err : status, o_done/o_err are one-cycle pulses
//   o_dbg_state         : current FSM state (0 IDLE, 1 CHECK, 2 WRITE, 3 DONE)
//   wb                  : Wishbone master port
// Command handshake: a command transfers on a rising edge where
// i_cmd_valid && o_cmd_ready; o_cmd_ready is high only while idle, and the
// requester keeps i_cmd_valid and the fields steady until that edge.
// -----------------------------------------------------------------------------
module wb_vga_fill #(
   parameter int H_RES = 320,
   parameter int V_RES = 240
) (
   input  logic        i_clk,
   input  logic        i_reset_n,
   input  logic        i_cmd_valid,
   output logic        o_cmd_ready,
   input  logic [8:0]  i_x0,
   input  logic [7:0]  i_y0,
   input  logic [8:0]  i_w,
   input  logic [7:0]  i_h,
   input  logic [15:0] i_color,
   input  logic        i_abort,
   output logic        o_busy,
   output logic        o_done,
   output logic        o_err,
   output logic [1:0]  o_dbg_state,
   wb_vga_fill_if.master wb
);

   localparam logic [9:0]  H_RES_W  = 10'(H_RES);
   localparam logic [9:0]  V_RES_W  = 10'(V_RES);
   localparam logic [16:0] H_RES_17 = 17'(H_RES);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_CHECK = 2'd1,
      S_WRITE = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t      r_state;
   state_t      w_next;

   logic [8:0]  r_x0;
   logic [8:0]  r_w;
   logic [7:0]  r_y0;
   logic [7:0]  r_h;
   logic [15:0] r_color;
   logic [16:0] r_base;       // pixel index of column 0 in the current row
   logic [9:0]  r_x;          // current column
   logic [7:0]  r_rows_left;  // rows still to go after the current one

   logic [9:0]  w_end_x;      // one past the last column of the rectangle
   logic        w_bad;
   logic [16:0] w_pix;
   logic        w_pair;
   logic [9:0]  w_x_nxt;
   logic        w_row_end;
   logic        w_last_row;

   // Bounds are checked at 10 bits so x0+w and y0+h cannot wrap.
   assign w_end_x    = {1'b0, r_x0} + {1'b0, r_w};
   assign w_bad      = (r_w == 9'd0) || (r_h == 8'd0) || (w_end_x > H_RES_W) ||
                       (({2'b00, r_y0} + {2'b00, r_h}) > V_RES_W);
   assign w_pix      = r_base + {7'd0, r_x};
   // Even pixel with its odd neighbour still inside the rectangle: full word.
   assign w_pair     = !w_pix[0] && ((r_x + 10'd2) <= w_end_x);
   assign w_x_nxt    = r_x + (w_pair ? 10'd2 : 10'd1);
   assign w_row_end  = (w_x_nxt >= w_end_x);
   assign w_last_row = (r_rows_left == 8'd0);

   assign o_dbg_state = r_state;

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) r_state <= S_IDLE;
      else            r_state <= w_next;
   end

   always_comb begin
      w_next      = r_state;
      o_cmd_ready = 1'b0;
      o_busy      = 1'b0;
      o_done      = 1'b0;
      o_err       = 1'b0;
      wb.cyc      = 1'b0;
      wb.stb      = 1'b0;
      wb.we       = 1'b0;
      wb.addr     = 16'd0;
      wb.data     = 32'd0;
      wb.sel      = 4'd0;
      case (r_state)
         S_IDLE: begin
            o_cmd_ready = 1'b1;
            if (i_cmd_valid) w_next = S_CHECK;
         end
         S_CHECK: begin
            o_busy = 1'b1;
            if (w_bad) begin
               o_err  = 1'b1;
               w_next = S_IDLE;
            end else begin
               w_next = S_WRITE;
            end
         end
         S_WRITE: begin
            o_busy  = 1'b1;
            wb.cyc  = 1'b1;
            wb.stb  = 1'b1;
            wb.we   = 1'b1;
            // Address/data/sel come only from registers that move on ack,
            // so they hold steady while the slave stalls.
            wb.addr = w_pix[16:1];
            wb.data = {r_color, r_color};
            wb.sel  = w_pair ? 4'b1111 : (w_pix[0] ? 4'b0011 : 4'b1100);
            if (i_abort)                                     w_next = S_IDLE;
            else if (wb.ack && w_row_end && w_last_row)      w_next = S_DONE;
         end
         S_DONE: begin
            o_done = 1'b1;
            w_next = S_IDLE;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_x0        <= 9'd0;
         r_w         <= 9'd0;
         r_y0        <= 8'd0;
         r_h         <= 8'd0;
         r_color     <= 16'd0;
         r_base      <= 17'd0;
         r_x         <= 10'd0;
         r_rows_left <= 8'd0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (i_cmd_valid) begin
                  r_x0    <= i_x0;
                  r_w     <= i_w;
                  r_y0    <= i_y0;
                  r_h     <= i_h;
                  r_color <= i_color;
               end
            end
            S_CHECK: begin
               r_base      <= 17'(r_y0) * H_RES_17;
               r_x         <= {1'b0, r_x0};
               r_rows_left <= r_h - 8'd1;
            end
            S_WRITE: begin
               // An ack in the abort cycle still retires its beat; the state
               // change to IDLE makes the remaining cursor values irrelevant.
               if (wb.ack) begin
                  if (w_row_end) begin
                     r_base      <= r_base + H_RES_17;
                     r_x         <= {1'b0, r_x0};
                     r_rows_left <= r_rows_left - 8'd1;
                  end else begin
                     r_x <= w_x_nxt;
                  end
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_wb_vga_fill.sv
// -----------------------------------------------------------------------------
// tb_wb_vga_fill
// Self-checking bench for wb_vga_fill. Expected bus beats come from a
// pixel-level reference model that walks the rectangle pixel by pixel and
// merges pixels sharing a framebuffer word into one beat.
// -----------------------------------------------------------------------------
module tb_wb_vga_fill;
   localparam int H = 320;
   localparam int V = 240;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [8:0]  x0 = '0;
   logic [7:0]  y0 = '0;
   logic [8:0]  w = '0;
   logic [7:0]  h = '0;
   logic [15:0] color = '0;
   logic        abort = 1'b0;
   logic        busy;
   logic        done;
   logic        err;
   logic [1:0]  dbg_state;

   wb_vga_fill_if wb ();

   wb_vga_fill #(.H_RES(H), .V_RES(V)) dut (
      .i_clk       (clk),
      .i_reset_n   (rst_n),
      .i_cmd_valid (cmd_valid),
      .o_cmd_ready (cmd_ready),
      .i_x0        (x0),
      .i_y0        (y0),
      .i_w         (w),
      .i_h         (h),
      .i_color     (color),
      .i_abort     (abort),
      .o_busy      (busy),
      .o_done      (done),
      .o_err       (err),
      .o_dbg_state (dbg_state),
      .wb          (wb)
   );

   // ---------------- scoreboard ----------------
   logic [51:0] exp_q[$];   // {addr[15:0], sel[3:0], data[31:0]}
   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Reference model: one beat per framebuffer word touched, in raster order.
   task automatic build_exp(input int ax0, input int ay0, input int aw, input int ah,
                            input logic [15:0] c);
      for (int y = ay0; y < ay0 + ah; y++) begin
         int last_word;
         logic [3:0] s;
         last_word = -1;
         s = 4'b0000;
         for (int x = ax0; x < ax0 + aw; x++) begin
            int p;
            int wd;
            logic [3:0] lane;
            p = y * H + x;
            wd = p / 2;
            lane = (p % 2 == 0) ? 4'b1100 : 4'b0011;
            if (wd == last_word) s = s | lane;
            else begin
               if (last_word >= 0) exp_q.push_back({16'(last_word), s, c, c});
               last_word = wd;
               s = lane;
            end
         end
         if (last_word >= 0) exp_q.push_back({16'(last_word), s, c, c});
      end
   endtask

   // ---------------- slave model + bus monitor ----------------
   int ack_mode = 0;       // 0 ack tied high, 1 three wait states, 2 random
   int wait_cnt = 0;
   int target = 3;
   int ncyc = 0;
   int beats_seen = 0;
   int done_cnt = 0;
   int err_cnt = 0;
   int cyc_cnt = 0;
   int last_ack_cyc = 0;
   int done_cyc = 0;
   logic held = 1'b0;
   logic [51:0] prev_beat = '0;
   logic [51:0] cur_beat;
   logic [51:0] e;

   always @(negedge clk) begin
      ncyc++;
      if (ack_mode == 0) wb.ack = 1'b1;
      else if (!(wb.cyc && wb.stb)) begin
         wb.ack = 1'b0;
         wait_cnt = 0;
      end else if (wait_cnt >= target) begin
         wb.ack = 1'b1;
         wait_cnt = 0;
         target = (ack_mode == 1) ? 3 : $urandom_range(0, 2);
      end else begin
         wb.ack = 1'b0;
         wait_cnt++;
      end

      if (rst_n) begin
         if (wb.cyc) begin
            cyc_cnt++;
            check("stb_we_with_cyc", {wb.stb, wb.we}, 2'b11);
         end
         cur_beat = {wb.addr, wb.sel, wb.data};
         if (wb.cyc && wb.stb) begin
            if (held) check("hold_stable", cur_beat, prev_beat);
            if (wb.ack) begin
               beats_seen++;
               last_ack_cyc = ncyc;
               held = 1'b0;
               check("beat_expected", exp_q.size() != 0, 1);
               if (exp_q.size() != 0) begin
                  e = exp_q.pop_front();
                  check("beat", cur_beat, e);
               end
            end else begin
               held = 1'b1;
               prev_beat = cur_beat;
            end
         end else begin
            held = 1'b0;
         end
         if (done) begin
            done_cnt++;
            done_cyc = ncyc;
         end
         if (err) err_cnt++;
      end
   end

   // ---------------- driver tasks ----------------
   task automatic set_mode(input int mode);
      ack_mode = mode;
      wait_cnt = 0;
      target = (mode == 1) ? 3 : $urandom_range(0, 2);
   endtask

   task automatic start_cmd(input int ax0, input int ay0, input int aw, input int ah,
                            input logic [15:0] c, input int mode, output bit ok);
      int t;
      ok = (aw > 0) && (ah > 0) && (ax0 + aw <= H) && (ay0 + ah <= V);
      @(negedge clk); #1;
      set_mode(mode);
      exp_q.delete();
      if (ok) build_exp(ax0, ay0, aw, ah, c);
      beats_seen = 0;
      done_cnt = 0;
      err_cnt = 0;
      cyc_cnt = 0;
      cmd_valid = 1'b1;
      x0 = 9'(ax0);
      y0 = 8'(ay0);
      w = 9'(aw);
      h = 8'(ah);
      color = c;
      t = 0;
      while (!cmd_ready && t < 100) begin
         @(negedge clk); #1;
         t++;
      end
      check("cmd_ready", cmd_ready, 1);
      @(posedge clk);
      @(negedge clk); #1;
      // Scramble the fields: the engine must have captured them already.
      cmd_valid = 1'b0;
      x0 = 9'($urandom);
      y0 = 8'($urandom);
      w = 9'($urandom);
      h = 8'($urandom);
      color = 16'($urandom);
      check("err_after_accept", err, !ok);
      check("busy_in_check", busy, 1);
      check("ready_low_busy", cmd_ready, 0);
   endtask

   task automatic run_cmd(input int ax0, input int ay0, input int aw, input int ah,
                          input logic [15:0] c, input int mode);
      bit ok;
      int n_exp;
      int t;
      int budget;
      start_cmd(ax0, ay0, aw, ah, c, mode, ok);
      n_exp = exp_q.size();
      budget = 8 * n_exp + 20;
      t = 0;
      while (done_cnt + err_cnt == 0 && t < budget) begin
         @(negedge clk); #1;
         t++;
      end
      check("finished_in_budget", done_cnt + err_cnt > 0, 1);
      repeat (3) @(negedge clk);
      #1;
      check("done_count", done_cnt, ok);
      check("err_count", err_cnt, !ok);
      check("exp_left", exp_q.size(), 0);
      if (ok) check("done_latency", done_cyc - last_ack_cyc, 1);
      else    check("no_bus_on_err", cyc_cnt, 0);
      if (mode == 0)      check("throughput", cyc_cnt, n_exp);
      else if (mode == 1) check("wait_cycles", cyc_cnt, 4 * n_exp);
      check("idle_ready", cmd_ready, 1);
      check("idle_busy", busy, 0);
   endtask

   task automatic wait_beats(input int n);
      int t;
      t = 0;
      while (beats_seen < n && t < 1000) begin
         @(negedge clk); #1;
         t++;
      end
      check("beat_wait", beats_seen == n, 1);
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int rw;
      int rh;
      int rx;
      int ry;
      bit ok;

      #1;
      check("rst_ready", cmd_ready, 1);
      check("rst_outs", {wb.cyc, wb.stb, wb.we, busy, done, err, wb.addr, wb.data, wb.sel}, 0);
      check("rst_state", dbg_state, 0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      run_cmd(0, 0, 2, 1, 16'hF800, 0);
      run_cmd(1, 0, 3, 1, 16'h1234, 0);
      run_cmd(4, 2, 1, 2, 16'hABCD, 0);
      run_cmd(319, 0, 2, 1, 16'h0F0F, 0);
      run_cmd(10, 10, 5, 0, 16'h0F0F, 0);
      run_cmd(10, 10, 0, 3, 16'h0F0F, 0);
      run_cmd(0, 200, 4, 41, 16'h0F0F, 0);
      run_cmd(316, 236, 4, 4, 16'h5A5A, 0);
      run_cmd(0, 0, 4, 1, 16'h07E0, 1);

      // Abort while idle is ignored.
      @(negedge clk); #1;
      abort = 1'b1;
      repeat (2) @(negedge clk);
      #1;
      check("abort_idle_ready", cmd_ready, 1);
      check("abort_idle_state", dbg_state, 0);
      abort = 1'b0;

      for (int i = 0; i < 16; i++) begin
         rw = $urandom_range(1, 24);
         rh = $urandom_range(1, 4);
         rx = $urandom_range(0, H - rw);
         ry = $urandom_range(0, V - rh);
         if ($urandom_range(0, 5) == 0) rx = $urandom_range(300, 319);
         if ($urandom_range(0, 7) == 0) rh = 0;
         run_cmd(rx, ry, rw, rh, 16'($urandom), $urandom_range(0, 2));
      end

      // Reset in the middle of a full-screen fill.
      start_cmd(0, 0, H, V, 16'h001F, 0, ok);
      wait_beats(100);
      rst_n = 1'b0;
      #1;
      check("midfill_rst_outs", {wb.cyc, wb.stb, wb.we, busy, done, err, wb.addr, wb.data, wb.sel}, 0);
      check("midfill_rst_ready", cmd_ready, 1);
      @(negedge clk); #1;
      rst_n = 1'b1;
      exp_q.delete();
      done_cnt = 0;
      repeat (5) @(negedge clk);
      #1;
      check("no_done_after_rst", done_cnt, 0);
      check("idle_after_rst", dbg_state, 0);

      // Abort at beat 5 of a new full-screen fill.
      start_cmd(0, 0, H, V, 16'hFFE0, 0, ok);
      wait_beats(5);
      abort = 1'b1;
      @(posedge clk);
      @(negedge clk); #1;
      abort = 1'b0;
      check("abort_cyc_low", wb.cyc, 0);
      check("abort_ready", cmd_ready, 1);
      check("abort_beats", beats_seen, 5);
      repeat (3) @(negedge clk);
      #1;
      check("abort_no_done", done_cnt, 0);
      check("abort_no_err", err_cnt, 0);
      exp_q.delete();

      run_cmd(7, 3, 9, 3, 16'h8421, 2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
